// File: rtl/audio_pkg.sv
// Shared audio definitions: default widths, SRAM track bank layout and the
// state encoding of the track mixer engine.
package audio_pkg;

   localparam int AUDIO_DATA_W  = 16;
   localparam int AUDIO_ADDR_W  = 18;
   localparam int BANK_A_BASE_C = 0;
   localparam int BANK_B_BASE_C = 128000;
   localparam int TRACK_LEN_C   = 128000;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD_A     = 3'd1,
      ST_RD_B     = 3'd2,
      ST_WR_SETUP = 3'd3,
      ST_WR_PULSE = 3'd4,
      ST_WR_HOLD  = 3'd5,
      ST_NEXT     = 3'd6,
      ST_FINISH   = 3'd7
   } mix_state_e;

endpackage

// File: rtl/sample_mix_alu.sv
// Combinational two-sample mixer. Default build averages (sign-extend, add,
// arithmetic shift right); SRAM_TRACK_MIXER_SAT_EN selects a saturating sum.
module sample_mix_alu #(
   parameter int DATA_W = 16
)(
   input  logic [DATA_W-1:0] sample_a,
   input  logic [DATA_W-1:0] sample_b,
   output logic [DATA_W-1:0] mix
);

   logic [DATA_W:0] sum_s;

   // Sign-extended sum and its reduction to DATA_W bits
   always_comb begin
      sum_s = {sample_a[DATA_W-1], sample_a} + {sample_b[DATA_W-1], sample_b};
`ifdef SRAM_TRACK_MIXER_SAT_EN
      // Overflow when the extra sign bit disagrees with the top result bit
      if (sum_s[DATA_W] != sum_s[DATA_W-1]) begin
         if (sum_s[DATA_W]) begin
            mix = {1'b1, {(DATA_W-1){1'b0}}};
         end else begin
            mix = {1'b0, {(DATA_W-1){1'b1}}};
         end
      end else begin
         mix = sum_s[DATA_W-1:0];
      end
`else
      mix = sum_s[DATA_W:1];
`endif
   end

endmodule

// File: rtl/sram_track_mixer.sv
// Mixes SRAM track banks A and B sample by sample into the destination bank.
// Optional build macro: SRAM_TRACK_MIXER_SAT_EN (saturating sum instead of average).
module sram_track_mixer
   import audio_pkg::*;
#(
   parameter int ADDR_W      = AUDIO_ADDR_W,
   parameter int DATA_W      = AUDIO_DATA_W,
   parameter int BANK_A_BASE = BANK_A_BASE_C,
   parameter int BANK_B_BASE = BANK_B_BASE_C,
   parameter int DEST_BASE   = BANK_A_BASE_C,
   parameter int LENGTH      = TRACK_LEN_C,
   parameter int WAIT_CYC    = 1
)(
   input  logic              iCLK,
   input  logic              iRST_N,
   input  logic              iStart,
   input  logic              iAbort,
   output logic              oBusy,
   output logic              oDone,
   output logic [ADDR_W-1:0] oCount,
   output logic [ADDR_W-1:0] oSRAM_ADDR,
   input  logic [DATA_W-1:0] iSRAM_DQ,
   output logic [DATA_W-1:0] oSRAM_DQ,
   output logic              oSRAM_DQ_OE,
   output logic              oSRAM_WE_N
);

   localparam logic [ADDR_W-1:0] A_BASE_C = ADDR_W'(BANK_A_BASE);
   localparam logic [ADDR_W-1:0] B_BASE_C = ADDR_W'(BANK_B_BASE);
   localparam logic [ADDR_W-1:0] D_BASE_C = ADDR_W'(DEST_BASE);
   localparam logic [ADDR_W-1:0] LEN_C    = ADDR_W'(LENGTH);
   localparam logic [2:0]        WAIT_C   = 3'(WAIT_CYC);

   mix_state_e        state_r, state_nx;
   logic [ADDR_W-1:0] index_r, index_nx;
   logic [2:0]        wait_r, wait_nx;
   logic [DATA_W-1:0] samp_a_r, samp_a_nx;
   logic              abort_r, abort_nx;
   logic              busy_r, busy_nx;
   logic              done_r, done_nx;
   logic [ADDR_W-1:0] count_r, count_nx;
   logic [ADDR_W-1:0] addr_r, addr_nx;
   logic [DATA_W-1:0] dq_r, dq_nx;
   logic              oe_r, oe_nx;
   logic              we_n_r, we_n_nx;
   logic [DATA_W-1:0] mix_s;
   logic              wait_last_s;
   logic [ADDR_W-1:0] index_inc_s;

   // Sample B is mixed straight off the bus on its last read cycle so the
   // registered write data is already valid in WR_SETUP.
   sample_mix_alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .sample_a (samp_a_r),
      .sample_b (iSRAM_DQ),
      .mix      (mix_s)
   );

   // Next-state and next-output decode; every output is registered below
   always_comb begin
      state_nx    = state_r;
      index_nx    = index_r;
      wait_nx     = wait_r;
      samp_a_nx   = samp_a_r;
      busy_nx     = busy_r;
      done_nx     = 1'b0;
      count_nx    = count_r;
      addr_nx     = addr_r;
      dq_nx       = dq_r;
      oe_nx       = oe_r;
      we_n_nx     = 1'b1;
      wait_last_s = (wait_r == WAIT_C);
      index_inc_s = index_r + ADDR_W'(1);

      if (busy_r && iAbort) begin
         abort_nx = 1'b1;
      end else begin
         abort_nx = abort_r;
      end

      case (state_r)
         ST_IDLE: begin
            if (iStart) begin
               state_nx = ST_RD_A;
               index_nx = {ADDR_W{1'b0}};
               count_nx = {ADDR_W{1'b0}};
               wait_nx  = 3'd0;
               busy_nx  = 1'b1;
               abort_nx = 1'b0;
               oe_nx    = 1'b0;
               addr_nx  = A_BASE_C;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         ST_RD_A: begin
            if (wait_last_s) begin
               samp_a_nx = iSRAM_DQ;
               state_nx  = ST_RD_B;
               wait_nx   = 3'd0;
               addr_nx   = B_BASE_C + index_r;
            end else begin
               wait_nx = wait_r + 3'd1;
            end
         end
         ST_RD_B: begin
            if (wait_last_s) begin
               state_nx = ST_WR_SETUP;
               wait_nx  = 3'd0;
               addr_nx  = D_BASE_C + index_r;
               dq_nx    = mix_s;
               oe_nx    = 1'b1;
            end else begin
               wait_nx = wait_r + 3'd1;
            end
         end
         ST_WR_SETUP: begin
            state_nx = ST_WR_PULSE;
            wait_nx  = 3'd0;
            we_n_nx  = 1'b0;
         end
         ST_WR_PULSE: begin
            if (wait_last_s) begin
               state_nx = ST_WR_HOLD;
               we_n_nx  = 1'b1;
            end else begin
               wait_nx = wait_r + 3'd1;
               we_n_nx = 1'b0;
            end
         end
         ST_WR_HOLD: begin
            state_nx = ST_NEXT;
            oe_nx    = 1'b0;
            count_nx = index_inc_s;
         end
         ST_NEXT: begin
            if ((index_inc_s == LEN_C) || abort_r || iAbort) begin
               state_nx = ST_FINISH;
               busy_nx  = 1'b0;
               done_nx  = 1'b1;
            end else begin
               state_nx = ST_RD_A;
               index_nx = index_inc_s;
               wait_nx  = 3'd0;
               addr_nx  = A_BASE_C + index_inc_s;
            end
         end
         ST_FINISH: begin
            state_nx = ST_IDLE;
            abort_nx = 1'b0;
         end
         default: begin
            state_nx = ST_IDLE;
            busy_nx  = 1'b0;
            oe_nx    = 1'b0;
            abort_nx = 1'b0;
         end
      endcase
   end

   // State, datapath and registered SRAM strobes
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_r  <= ST_IDLE;
         index_r  <= {ADDR_W{1'b0}};
         wait_r   <= 3'd0;
         samp_a_r <= {DATA_W{1'b0}};
         abort_r  <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         count_r  <= {ADDR_W{1'b0}};
         addr_r   <= {ADDR_W{1'b0}};
         dq_r     <= {DATA_W{1'b0}};
         oe_r     <= 1'b0;
         we_n_r   <= 1'b1;
      end else begin
         state_r  <= state_nx;
         index_r  <= index_nx;
         wait_r   <= wait_nx;
         samp_a_r <= samp_a_nx;
         abort_r  <= abort_nx;
         busy_r   <= busy_nx;
         done_r   <= done_nx;
         count_r  <= count_nx;
         addr_r   <= addr_nx;
         dq_r     <= dq_nx;
         oe_r     <= oe_nx;
         we_n_r   <= we_n_nx;
      end
   end

   assign oBusy       = busy_r;
   assign oDone       = done_r;
   assign oCount      = count_r;
   assign oSRAM_ADDR  = addr_r;
   assign oSRAM_DQ    = dq_r;
   assign oSRAM_DQ_OE = oe_r;
   assign oSRAM_WE_N  = we_n_r;

endmodule

// File: tb/tb_sram_track_mixer.sv
// Scoreboard bench for sram_track_mixer: a LENGTH=1 and a LENGTH=4 instance,
// each with a small sparse SRAM model; writes and done pulses are checked by monitors.
module tb_sram_track_mixer;

   typedef struct {
      int          inst;
      logic [17:0] addr;
      logic [15:0] data;
   } wr_t;

   typedef struct {
      int inst;
      int count;
      int lat;
   } done_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #10 clk = ~clk;

   logic        start_1 = 1'b0, abort_1 = 1'b0, start_4 = 1'b0, abort_4 = 1'b0;
   logic        busy_1, done_1, oe_1, we_n_1, busy_4, done_4, oe_4, we_n_4;
   logic [17:0] count_1, addr_1, count_4, addr_4;
   logic [15:0] rdq_1, wdq_1, rdq_4, wdq_4;
   logic [15:0] mem1 [32];
   logic [15:0] mem4 [32];

   int    n_cmp = 0;
   int    n_bad = 0;
   int    cyc = 0;
   int    start_cyc = 0;
   logic  track3 = 1'b0;
   logic  seen3 = 1'b0;
   logic  pwe_1 = 1'b1, pwe_4 = 1'b1;
   logic [17:0] paddr_1 = 18'd0, paddr_4 = 18'd0;
   wr_t   wq[$];
   done_t dq[$];

   function automatic int slot(input logic [17:0] a);
      logic [17:0] d;
      d = a - 18'd128000;
      if (a >= 18'd128000) return 16 + int'(d[3:0]);
      else return int'(a[3:0]);
   endfunction

   assign rdq_1 = mem1[slot(addr_1)];
   assign rdq_4 = mem4[slot(addr_4)];

   sram_track_mixer #(.LENGTH(1), .WAIT_CYC(1)) u1 (
      .iCLK(clk), .iRST_N(rst_n), .iStart(start_1), .iAbort(abort_1),
      .oBusy(busy_1), .oDone(done_1), .oCount(count_1), .oSRAM_ADDR(addr_1),
      .iSRAM_DQ(rdq_1), .oSRAM_DQ(wdq_1), .oSRAM_DQ_OE(oe_1), .oSRAM_WE_N(we_n_1)
   );

   sram_track_mixer #(.LENGTH(4), .DEST_BASE(0), .WAIT_CYC(1)) u4 (
      .iCLK(clk), .iRST_N(rst_n), .iStart(start_4), .iAbort(abort_4),
      .oBusy(busy_4), .oDone(done_4), .oCount(count_4), .oSRAM_ADDR(addr_4),
      .iSRAM_DQ(rdq_4), .oSRAM_DQ(wdq_4), .oSRAM_DQ_OE(oe_4), .oSRAM_WE_N(we_n_4)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic on_write(input int k, input logic [17:0] a, input logic [15:0] d);
      wr_t e;
      if (k == 0) mem1[slot(a)] = d;
      else mem4[slot(a)] = d;
      if (wq.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL unexpected_write: inst %0d addr 0x%0h data 0x%0h, required no write", k, a, d);
      end else begin
         e = wq.pop_front();
         check("wr_inst", k, e.inst);
         check("wr_addr", 32'(a), 32'(e.addr));
         check("wr_data", 32'(d), 32'(e.data));
      end
   endtask

   task automatic on_done(input int k, input logic [17:0] cnt);
      done_t e;
      if (dq.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL unexpected_done: inst %0d count %0d, required no done", k, cnt);
      end else begin
         e = dq.pop_front();
         check("done_inst", k, e.inst);
         check("done_count", 32'(cnt), e.count);
         check("done_latency", cyc - start_cyc + 1, e.lat);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge we_n_1) if (rst_n) on_write(0, addr_1, wdq_1);
   always @(posedge we_n_4) if (rst_n) on_write(1, addr_4, wdq_4);

   // Bus protocol and done monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (rst_n) begin
         if (!we_n_1) begin
            check("we_without_oe_1", oe_1, 1);
            if (!pwe_1) check("addr_moved_in_we_1", 32'(addr_1), 32'(paddr_1));
         end
         if (!we_n_4) begin
            check("we_without_oe_4", oe_4, 1);
            if (!pwe_4) check("addr_moved_in_we_4", 32'(addr_4), 32'(paddr_4));
         end
         if (!busy_4) check("idle_strobes_4", {oe_4, we_n_4}, 2'b01);
         if (track3 && busy_4 && addr_4 == 18'd3) seen3 = 1'b1;
         if (done_1) on_done(0, count_1);
         if (done_4) on_done(1, count_4);
      end
      pwe_1 = we_n_1;
      pwe_4 = we_n_4;
      paddr_1 = addr_1;
      paddr_4 = addr_4;
   end

   task automatic start_run(input int k, input logic with_abort);
      @(negedge clk);
      if (k == 0) begin
         start_1 = 1'b1;
         abort_1 = with_abort;
      end else begin
         start_4 = 1'b1;
         abort_4 = with_abort;
      end
      @(posedge clk);
      #1 start_cyc = cyc;
      @(negedge clk);
      start_1 = 1'b0;
      abort_1 = 1'b0;
      start_4 = 1'b0;
      abort_4 = 1'b0;
   endtask

   task automatic wait_drain(input int bound, input string tag);
      for (int i = 0; i < bound && (wq.size() != 0 || dq.size() != 0); i++) @(negedge clk);
      n_cmp++;
      if (wq.size() != 0 || dq.size() != 0) begin
         n_bad++;
         $display("FAIL %s_timeout: %0d writes and %0d dones pending, required 0", tag, wq.size(), dq.size());
         wq.delete();
         dq.delete();
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic load4(input logic [15:0] a0, a1, a2, a3, b0, b1, b2, b3);
      mem4[0] = a0; mem4[1] = a1; mem4[2] = a2; mem4[3] = a3;
      mem4[16] = b0; mem4[17] = b1; mem4[18] = b2; mem4[19] = b3;
   endtask

   task automatic push4(input int n, input logic [15:0] e0, e1, e2, e3, input int lat);
      logic [15:0] e [4];
      e = '{e0, e1, e2, e3};
      for (int i = 0; i < n; i++) wq.push_back('{1, 18'(i), e[i]});
      dq.push_back('{1, n, lat});
   endtask

   logic [15:0] t_a [7];
   logic [15:0] t_b [7];
   logic [15:0] t_e [7];

   initial begin
      for (int i = 0; i < 32; i++) begin
         mem1[i] = 16'h0000;
         mem4[i] = 16'h0000;
      end
      t_a = '{16'h1000, 16'h8000, 16'h7FFF, 16'h0001, 16'h4000, 16'h0003, 16'h8001};
      t_b = '{16'h3000, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h4000, 16'h0000, 16'hFFFF};
`ifdef SRAM_TRACK_MIXER_SAT_EN
      t_e = '{16'h4000, 16'h8000, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h0003, 16'h8000};
`else
      t_e = '{16'h2000, 16'h8000, 16'h7FFF, 16'h0000, 16'h4000, 16'h0001, 16'hC000};
`endif

      repeat (3) @(negedge clk);
      check("rst_busy", busy_4, 0);
      check("rst_done", done_4, 0);
      check("rst_count", 32'(count_4), 0);
      check("rst_addr", 32'(addr_4), 0);
      check("rst_dq", 32'(wdq_4), 0);
      check("rst_oe", oe_4, 0);
      check("rst_we_n", we_n_4, 1);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single-sample runs, including signed extremes
      for (int v = 0; v < 7; v++) begin
         mem1[0] = t_a[v];
         mem1[16] = t_b[v];
         wq.push_back('{0, 18'd0, t_e[v]});
         dq.push_back('{0, 1, 10});
         start_run(0, 1'b0);
         wait_drain(40, "single");
         check("single_count_hold", 32'(count_1), 1);
      end

      // Full overlapping run; a second start while busy must be ignored
      load4(16'h0100, 16'h0200, 16'hFFFE, 16'h7FFF, 16'h0300, 16'h0400, 16'h0002, 16'h8000);
`ifdef SRAM_TRACK_MIXER_SAT_EN
      push4(4, 16'h0400, 16'h0600, 16'h0000, 16'hFFFF, 37);
`else
      push4(4, 16'h0200, 16'h0300, 16'h0000, 16'hFFFF, 37);
`endif
      start_run(1, 1'b0);
      repeat (15) @(negedge clk);
      start_4 = 1'b1;
      @(negedge clk);
      start_4 = 1'b0;
      wait_drain(80, "full");
      check("full_count_hold", 32'(count_4), 4);
      check("full_busy_after", busy_4, 0);

      // Abort alone in IDLE, then start+abort together: both give a full run
      abort_4 = 1'b1;
      @(negedge clk);
      abort_4 = 1'b0;
      repeat (2) @(negedge clk);
      load4(16'h0100, 16'h0200, 16'hFFFE, 16'h7FFF, 16'h0300, 16'h0400, 16'h0002, 16'h8000);
`ifdef SRAM_TRACK_MIXER_SAT_EN
      push4(4, 16'h0400, 16'h0600, 16'h0000, 16'hFFFF, 37);
`else
      push4(4, 16'h0200, 16'h0300, 16'h0000, 16'hFFFF, 37);
`endif
      start_run(1, 1'b1);
      wait_drain(80, "start_abort");

      // Abort during RD_B of sample 2: sample 2 written, nothing of sample 3
      load4(16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h1000, 16'h0000, 16'hF000, 16'h0000);
`ifdef SRAM_TRACK_MIXER_SAT_EN
      push4(3, 16'h2000, 16'h2000, 16'h2000, 16'h4000, 28);
`else
      push4(3, 16'h1000, 16'h1000, 16'h1000, 16'h2000, 28);
`endif
      seen3 = 1'b0;
      track3 = 1'b1;
      start_run(1, 1'b0);
      repeat (20) @(negedge clk);
      abort_4 = 1'b1;
      @(negedge clk);
      abort_4 = 1'b0;
      wait_drain(80, "abort");
      track3 = 1'b0;
      check("abort_count", 32'(count_4), 3);
      check("abort_no_sample3", seen3, 0);

      // Reset in the middle of a write pulse
      load4(16'h0100, 16'h0200, 16'hFFFE, 16'h7FFF, 16'h0300, 16'h0400, 16'h0002, 16'h8000);
      start_run(1, 1'b0);
      repeat (5) @(negedge clk);
      check("pre_reset_we_low", we_n_4, 0);
      rst_n = 1'b0;
      #1;
      check("mid_reset_we_n", we_n_4, 1);
      check("mid_reset_oe", oe_4, 0);
      check("mid_reset_busy", busy_4, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("post_reset_count", 32'(count_4), 0);
      load4(16'h0100, 16'h0200, 16'hFFFE, 16'h7FFF, 16'h0300, 16'h0400, 16'h0002, 16'h8000);
`ifdef SRAM_TRACK_MIXER_SAT_EN
      push4(4, 16'h0400, 16'h0600, 16'h0000, 16'hFFFF, 37);
`else
      push4(4, 16'h0200, 16'h0300, 16'h0000, 16'hFFFF, 37);
`endif
      start_run(1, 1'b0);
      wait_drain(80, "after_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
